// File: rtl/matmul_pkg.sv
// Shared matrix-multiplier definitions: default sizes, loader
// state encoding and lane packing helper.
package matmul_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_N           = 8;
   localparam int DEF_DEPTH       = 8;
   localparam int DEF_MEM_LATENCY = 2;

   typedef enum logic [1:0] {
      FILL,
      READY,
      FEED,
      DONE
   } ld_state_e;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/latency_delay_line.sv
// Fixed-latency shift register that re-times the controller's
// strobe/select bundle to the memory read latency.
module latency_delay_line #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_pipe [LATENCY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[LATENCY-1];

endmodule

// File: rtl/operand_bank_loader.sv
// Operand capture banks for matrices A/B feeding the systolic array.
// Define SKEW_EN for diagonal lane skew; otherwise lanes run aligned.
module operand_bank_loader
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int N           = DEF_N,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [$clog2(N):0]      bank_sel,
   input  logic [$clog2(DEPTH)-1:0] elem_sel,
   input  logic [DATA_WIDTH-1:0]   rom_data,
   input  logic [DATA_WIDTH-1:0]   ram_data,
   input  logic                    feed_start,
   input  logic                    feed_ready,
   output logic [N*DATA_WIDTH-1:0] a_out,
   output logic [N*DATA_WIDTH-1:0] b_out,
   output logic [N-1:0]            lane_valid,
   output logic                    loaded,
   output logic                    feed_busy,
   output logic                    feed_done,
   output logic                    overrun_err
);

   localparam int BW  = $clog2(N) + 1;
   localparam int LBW = $clog2(N);
   localparam int EW  = $clog2(DEPTH);
   localparam int PW  = 1 + BW + EW;
   localparam int TW  = $clog2(DEPTH + N);
`ifdef SKEW_EN
   localparam int LAST = DEPTH + N - 2;
`else
   localparam int LAST = DEPTH - 1;
`endif

   logic [PW-1:0] w_pipe_q;
   logic          w_d_wr;
   logic [BW-1:0] w_d_bank;
   logic [EW-1:0] w_d_elem;

   latency_delay_line #(
      .WIDTH  (PW),
      .LATENCY(MEM_LATENCY)
   ) u_dly (
      .clk  (clk),
      .reset(reset),
      .i_d  ({wr_en, bank_sel, elem_sel}),
      .o_q  (w_pipe_q)
   );

   assign {w_d_wr, w_d_bank, w_d_elem} = w_pipe_q;

   ld_state_e r_state, w_state_nxt;
   logic [TW-1:0] r_t, w_t_nxt;
   logic [DATA_WIDTH-1:0] r_a [N][DEPTH];
   logic [DATA_WIDTH-1:0] r_b [N][DEPTH];
   logic [N-1:0][DEPTH-1:0] r_valid, w_wmask;
   logic r_ovr;
   logic [N*DATA_WIDTH-1:0] r_a_out, r_b_out, w_a_beat, w_b_beat;
   logic [N-1:0] r_v_out, w_v_beat;
   logic w_hit, w_open, w_we, w_all;

   // Terminal-count bank values never reach the banks
   assign w_hit  = w_d_wr && (w_d_bank < BW'(N));
   assign w_open = (r_state == FILL) || (r_state == READY);
   assign w_we   = w_hit && w_open;

   always_comb begin
      w_wmask = '0;
      if (w_we) w_wmask[w_d_bank[LBW-1:0]][w_d_elem] = 1'b1;
   end

   assign w_all = &(r_valid | w_wmask);

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      unique case (r_state)
         FILL:  if (w_all) w_state_nxt = READY;
         READY: if (feed_start) begin
            w_state_nxt = FEED;
            w_t_nxt     = '0;
         end
         FEED:  if (feed_ready) begin
            if (r_t == TW'(LAST)) begin
               w_state_nxt = DONE;
               w_t_nxt     = '0;
            end else begin
               w_t_nxt = r_t + 1'b1;
            end
         end
         DONE:  w_state_nxt = FILL;
         default: w_state_nxt = FILL;
      endcase
   end

   // Beat for the step that will be current after this edge
   always_comb begin
      int k;
      k        = 0;
      w_a_beat = '0;
      w_b_beat = '0;
      w_v_beat = '0;
      if (w_state_nxt == FEED) begin
         for (int i = 0; i < N; i++) begin
`ifdef SKEW_EN
            k = int'(w_t_nxt) - i;
`else
            k = int'(w_t_nxt);
`endif
            if (k >= 0 && k < DEPTH) begin
               w_a_beat[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = r_a[i][k[EW-1:0]];
               w_b_beat[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = r_b[i][k[EW-1:0]];
               w_v_beat[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FILL;
         r_t     <= '0;
         r_valid <= '0;
         r_ovr   <= 1'b0;
         r_a_out <= '0;
         r_b_out <= '0;
         r_v_out <= '0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               r_a[i][j] <= '0;
               r_b[i][j] <= '0;
            end
         end
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
         r_a_out <= w_a_beat;
         r_b_out <= w_b_beat;
         r_v_out <= w_v_beat;
         if (r_state == DONE) r_valid <= '0;
         else r_valid <= r_valid | w_wmask;
         if (w_hit && !w_open) r_ovr <= 1'b1;
         if (w_we) begin
            r_a[w_d_bank[LBW-1:0]][w_d_elem] <= rom_data;
            r_b[w_d_bank[LBW-1:0]][w_d_elem] <= ram_data;
         end
      end
   end

   assign a_out       = r_a_out;
   assign b_out       = r_b_out;
   assign lane_valid  = r_v_out;
   assign loaded      = (r_state == READY);
   assign feed_busy   = (r_state == FEED);
   assign feed_done   = (r_state == DONE);
   assign overrun_err = r_ovr;

endmodule

// File: doc/operand_bank_loader.md
# operand_bank_loader

Captures matrix operands returned by the operand ROM (matrix A) and the operand RAM (matrix B). The write strobe and bank/element selects come from the matrix-multiplier controller, and the block re-times them to match the memories' 2-cycle read latency. It stores the operands in an N×DEPTH register bank per matrix. On request, it streams them row/column-wise, skewed, into the systolic MAC array. It sits directly downstream of the controller and memories and directly upstream of the MAC array.

## Interface
- DATA_WIDTH, 32: operand width.
- N, 8: number of banks, equal to array lanes; bank index range is 0..N-1.
- DEPTH, 8: elements per bank.
- MEM_LATENCY, 2: cycles from strobe to data valid at rom_data/ram_data.
- clk, input, 1: clock; all state on rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- wr_en, input, 1: controller read enable, qualifying the selects this cycle.
- bank_sel, input, $clog2(N)+1: bank index; value N is the controller's terminal count and is never written.
- elem_sel, input, $clog2(DEPTH): element index within bank.
- rom_data, input, DATA_WIDTH: matrix A word, valid MEM_LATENCY cycles after its strobe.
- ram_data, input, DATA_WIDTH: matrix B word, same latency.
- feed_start, input, 1: request to stream the loaded operands; honoured only in READY.
- feed_ready, input, 1: array accepts the current beat.
- a_out, output, N*DATA_WIDTH: lane i A operand at bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_out, output, N*DATA_WIDTH: lane i B operand, same packing.
- lane_valid, output, N: per-lane beat valid.
- loaded, output, 1: all N*DEPTH slots written; high in READY.
- feed_busy, output, 1: high in FEED.
- feed_done, output, 1: one-cycle pulse in DONE.
- overrun_err, output, 1: sticky; cleared only by reset.

## Operation
- Capture pipe: {wr_en, bank_sel, elem_sel} delayed MEM_LATENCY cycles.
  - Write condition: the delayed wr_en is 1, the delayed bank_sel < N, and the state is FILL or READY.
  - On write: A[bank][elem] ← rom_data, B[bank][elem] ← ram_data, valid[bank][elem] ← 1.
  - A repeat write to the same slot overwrites it.
  - A delayed bank_sel ≥ N is silently dropped.
- States:
  - FILL: go to READY when all valid bits are set; this check includes a write landing that cycle.
  - READY: stay until feed_start; go to FEED on the next edge.
  - FEED: step counter t runs 0..DEPTH+N-2 and advances only on cycles with feed_ready=1.
    - Lane i presents A[i][t-i], B[i][t-i] with lane_valid[i]=1 when 0 ≤ t-i < DEPTH.
    - Otherwise lane i presents zero data with lane_valid[i]=0.
    - On the edge accepting t=DEPTH+N-2, go to DONE.
  - DONE: assert feed_done, clear all valid bits, go to FILL. Data registers are not cleared.
- A delayed write arriving in FEED or DONE is dropped and sets overrun_err.
- feed_start outside READY is ignored.

## Timing
- Reset value of every output is 0: a_out, b_out, lane_valid, loaded, feed_busy, feed_done, overrun_err. State resets to FILL, t to 0, and all valid bits, pipe stages and data registers to 0.
- Reset is asynchronous and takes effect mid-FILL or mid-FEED; no partial stream resumes after release.
- Write latency: the strobe at edge k lands in the bank at edge k+MEM_LATENCY. loaded rises on the edge that writes the last slot.
- The first beat (t=0) is on the outputs in the cycle after feed_start is sampled. Outputs are registered, and beat t holds until feed_ready=1.
- Full feed duration with feed_ready tied high: N+DEPTH-1 cycles in FEED, plus 1 cycle in DONE.

## Configuration
- SKEW_EN defined: diagonal skew as above; N+DEPTH-1 beats.
- SKEW_EN undefined:
  - All lanes present element t simultaneously.
  - t runs 0..DEPTH-1 and all lane_valid bits are 1 on every beat.
  - DEPTH beats total; the MAC array applies its own skew.

## Structure
- Shared package `matmul_pkg`:
  - DATA_WIDTH, N, DEPTH, MEM_LATENCY defaults.
  - Loader state enum {FILL, READY, FEED, DONE}.
  - Lane slice helper constant/function.
- One sub-module: `latency_delay_line`, a parameterised width×MEM_LATENCY shift register with async reset, used for the strobe/select pipe.

## Test plan
- Full load, then feed:
  - Stimulus: N=DEPTH=8; drive 64 strobes, bank 0..7 × elem 0..7, rom_data=bank*8+elem, ram_data=100+bank*8+elem; then feed_start with feed_ready=1.
  - Response: loaded rises 2 cycles after the last strobe.
  - Beat t=3: lane 0 A=3; lane 3 A=24 with valid; lanes 4..7 invalid.
  - Exactly 15 beats, then the feed_done pulse.
- Backpressure:
  - Stimulus: toggle feed_ready 1/0 each cycle.
  - Response: each beat is held while feed_ready=0; the sequence is identical to the previous test and the feed takes 30 cycles.
- Terminal select:
  - Stimulus: strobe with bank_sel=8.
  - Response: no write; valid count is unchanged.
- Overrun:
  - Stimulus: strobe issued 2 cycles before FEED is entered.
  - Response: write dropped; overrun_err=1 and stays 1 after DONE.
- Reset mid-feed:
  - Stimulus: assert reset at beat t=5.
  - Response: all outputs are 0 immediately; after release, state is FILL and loaded=0.
- SKEW_EN undefined:
  - Stimulus: same load as the first test, then feed_start.
  - Response: 8 beats; beat 2 gives lane i A=i*8+2, with all lane_valid set.
